dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the slave side of the CPU data port. It accepts one load or store at a time over a req/addr_ok/data_ok handshake, and models a fixed, parameterised access latency. Stores are byte-enabled and loads return a raw word. It sits between the pipelined MIPS core's memory stage and the on-chip data RAM, and it stands in for the bus bridge in simulation and FPGA builds.

## Interface
- ADDR_W, 10: word-address width; memory depth is 2^ADDR_W words.
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
- clk  in  1  clock; one clock domain; everything is sampled on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  CPU request valid.
- wr  in  1  1 = store, 0 = load; qualified by req.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- addr  in  32  byte address; only addr[ADDR_W+1:0] is used.
- wdata  in  32  store data, already lane-aligned by the CPU.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  one-cycle pulse: the response for the accepted request.
- rdata  out  32  full read word; valid while data_ok is high; held until the next response.
- err  out  1  misalignment flag; valid while data_ok is high.

## Operation
- FSM states:
  - IDLE: addr_ok=1.
  - WAIT: addr_ok=0; counts down the remaining latency.
  - RESP: data_ok=1, addr_ok=1.
- Handshake: a request is accepted when req and addr_ok are both high. On acceptance the responder captures wr, size, addr and wdata; CPU inputs are ignored afterwards.
- Only one request is outstanding at a time. A new request may be accepted in the RESP cycle, which gives back-to-back transfers.
- State transitions on acceptance:
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with the counter loaded to LATENCY-2. The counter decrements each cycle; at 0 the FSM goes to RESP.
- RESP with no new request: go to IDLE.
- Byte enables come from size and addr[1:0]:
  - byte → 1<<addr[1:0]
  - half → 0011 or 1100 by addr[1]
  - word → 1111
- Misaligned accesses are: half with addr[0]=1, word with addr[1:0]≠0, and size=3. For these, no write is performed, rdata is 0 and err=1 in RESP.
- Memory commit happens on the clock edge that enters RESP:
  - Store: only enabled lanes are written; rdata is 0.
  - Load: rdata takes the full word at addr[ADDR_W+1:2].
- Upper address bits are ignored, so the word index wraps modulo 2^ADDR_W.
- A load and a store to the same word in back-to-back transfers are ordered by acceptance: the later load sees the earlier store.

## Timing
- Request accepted at edge T → data_ok high during cycle T+LATENCY, for exactly one cycle.
- Back-to-back throughput is one transfer every LATENCY cycles.
- addr_ok is a registered-state decode with no combinational path from req.
- rdata and err are registered.
- While rst is high at a clock edge, the responder enters or stays in IDLE. Reset values:
  - addr_ok=0 while rst is high.
  - data_ok=0, err=0, rdata=0.
  - Counter cleared.
- Reset mid-operation (WAIT) drops the transfer: no write is committed and no data_ok is produced. Memory contents are not cleared by reset.
- addr_ok returns to 1 in the first cycle after rst deasserts.

## Structure
- The shared package `dmem_pkg` holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - FSM state encodings ST_IDLE/ST_WAIT/ST_RESP
  - default LATENCY
- Sub-module `dmem_be_gen` is purely combinational: it maps (size, addr[1:0]) → be[3:0] plus a misaligned flag. It is reused by the CPU-side store-lane logic.
- Memory is an inferred RAM array of 2^ADDR_W × 32 with per-byte write enables. Reads are synchronous at the commit edge.

## Test plan
- Reset then word store: store addr=0x10, wdata=0xDEADBEEF, LATENCY=2 → accepted at T, data_ok at T+2, err=0. A word load from 0x10 → rdata=0xDEADBEEF.
- Byte/half lanes: preload word 0x10=0x00000000. Store byte 0xAA at 0x13 (wdata=0xAAAAAAAA) and half 0x5555 at 0x10 (wdata=0x55555555). A word load then returns 0xAA005555.
- Misalignment: word store at 0x22 → data_ok with err=1, and word 0x20 is unchanged. Half load at 0x21 → err=1, rdata=0.
- Back-to-back: hold req high for 4 loads with LATENCY=1 → data_ok high for 4 consecutive cycles, with addr_ok high every cycle.
- Reset mid-WAIT: with LATENCY=4, accept a store to 0x40 (0x12345678) and assert rst one cycle later → no data_ok, addr_ok=0 during reset. A load from 0x40 afterwards returns the old value.
- Wrap: ADDR_W=10, store 0xCAFEF00D at 0x1000 → a load from 0x0000 returns 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: size and FSM encodings, default latency and captured-request type for dmem_responder
package dmem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int DEF_LATENCY = 2;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/dmem_be_gen.sv
// dmem_be_gen: maps access size and byte offset to byte-lane enables and a misalignment flag
//   size       in  2  access size (byte/half/word, 3 illegal)
//   addr_lo    in  2  addr[1:0]
//   be         out 4  byte-lane enables
//   misaligned out 1  half on odd byte, word off word boundary, or illegal size
module dmem_be_gen
  import dmem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);
  assign be = size == SIZE_BYTE ? 4'b0001 << addr_lo :
              size == SIZE_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
              size == SIZE_WORD ? 4'b1111 : 4'b0000;
  assign misaligned = size == SIZE_HALF ? addr_lo[0] :
                      size == SIZE_WORD ? |addr_lo : size != SIZE_BYTE;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with fixed access latency and byte-enabled stores
//   clk, rst                     clock, synchronous active-high reset
//   req, wr, size, addr, wdata   CPU request, captured when req && addr_ok
//   addr_ok                      ready to accept a request this cycle
//   data_ok, rdata, err          one-cycle response pulse with registered read word and misalignment flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);
  localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  logic [1:0] state;
  logic [3:0] cnt;
  dmem_req_t cap, op;
  logic accept, commit, mis;
  logic [3:0] be;
  logic [ADDR_W-1:0] idx;
  logic [31:0] mem [2**ADDR_W];
  assign addr_ok = !rst && state != ST_WAIT;
  assign data_ok = state == ST_RESP;
  assign accept = req && addr_ok;
  // With single-cycle latency the commit edge is the acceptance edge, so the live inputs are used.
  assign op = LATENCY == 1 ? dmem_req_t'{wr, size, addr, wdata} : cap;
  assign commit = LATENCY == 1 ? accept : state == ST_WAIT && cnt == 4'd0;
  assign idx = op.addr[ADDR_W+1:2];
  dmem_be_gen u_be (
    .size      (op.size),
    .addr_lo   (op.addr[1:0]),
    .be        (be),
    .misaligned(mis)
  );
  always_ff @(posedge clk) begin
    if (commit && !rst && op.wr && !mis)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= op.wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (accept) cap <= dmem_req_t'{wr, size, addr, wdata};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= accept ? (LATENCY == 1 ? ST_RESP : ST_WAIT) :
               state == ST_WAIT ? (cnt == 4'd0 ? ST_RESP : ST_WAIT) : ST_IDLE;
      cnt   <= accept ? CNT_INIT : (state == ST_WAIT && cnt != 4'd0 ? cnt - 4'd1 : cnt);
      if (commit) begin
        rdata <= op.wr || mis ? '0 : mem[idx];
        err   <= mis;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 2, 1, 4) against a transaction-level model plus directed literal checks
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int per = 0;
  always @(posedge clk) per <= per + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic bit misal(input logic [1:0] s, input logic [1:0] o);
    return s == 2'd3 || (s == 2'd1 && o[0]) || (s == 2'd2 && o != 2'd0);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = g == 0 ? 2 : g == 1 ? 1 : 4;
    logic rst, req, wr, addr_ok, data_ok, err;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata;
    bit done = 0;
    dmem_responder #(.ADDR_W(10), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err)
    );
    logic [31:0] mmem [1024];
    bit pend = 0;
    int due = 0;
    int ix, o;
    bit eao, edo;
    logic m_wr, m_err;
    logic [1:0] m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    always @(negedge clk) begin
      eao = !rst && (!pend || due <= per);
      edo = pend && due == per;
      chk($sformatf("L%0d addr_ok", L), {31'd0, addr_ok}, {31'd0, eao});
      chk($sformatf("L%0d data_ok", L), {31'd0, data_ok}, {31'd0, edo});
      if (edo) begin
        chk($sformatf("L%0d rdata", L), rdata, m_rdata);
        chk($sformatf("L%0d err", L), {31'd0, err}, {31'd0, m_err});
      end
      if (rst) begin
        pend = 0;
        m_rdata = 0;
        m_err = 0;
      end else begin
        if (req && eao) begin
          pend = 1;
          due = per + L;
          m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata;
        end
        if (pend && due == per + 1) begin
          ix = int'(m_addr[11:2]);
          o = int'(m_addr[1:0]);
          m_err = misal(m_size, m_addr[1:0]);
          m_rdata = (m_err || m_wr) ? 32'd0 : mmem[ix];
          if (!m_err && m_wr)
            for (int k = o; k < o + (1 << m_size); k++) mmem[ix][8*k +: 8] = m_wdata[8*k +: 8];
        end
      end
    end
    task automatic op(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] ro, output logic eo, output int lat);
      bit acc, got;
      int aper;
      acc = 0; got = 0; aper = 0; ro = 'x; eo = 1'bx; lat = -1;
      @(posedge clk) #1;
      req = 1; wr = w; size = s; addr = a; wdata = d;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        if (addr_ok) begin acc = 1; aper = per; end
      end
      @(posedge clk) #1;
      req = 0;
      if (!acc) chk($sformatf("L%0d accept_timeout", L), {31'd0, acc}, 32'd1);
      else begin
        for (int t = 0; t < 40 && !got; t++) begin
          @(negedge clk);
          if (data_ok) begin got = 1; ro = rdata; eo = err; lat = per - aper; end
        end
        if (!got) chk($sformatf("L%0d data_ok_timeout", L), {31'd0, got}, 32'd1);
      end
    endtask
    initial begin
      logic [31:0] r;
      logic e;
      int lat;
      rst = 1; req = 0; wr = 0; size = 0; addr = 0; wdata = 0;
      repeat (2) @(negedge clk);
      chk($sformatf("L%0d reset addr_ok", L), {31'd0, addr_ok}, 32'd0);
      chk($sformatf("L%0d reset data_ok", L), {31'd0, data_ok}, 32'd0);
      chk($sformatf("L%0d reset rdata", L), rdata, 32'd0);
      chk($sformatf("L%0d reset err", L), {31'd0, err}, 32'd0);
      @(posedge clk) #1;
      rst = 0;
      @(negedge clk);
      chk($sformatf("L%0d addr_ok after reset", L), {31'd0, addr_ok}, 32'd1);
      for (int i = 0; i < 24; i++) op(1, 2, 32'(i * 4), 32'h1000_0000 + 32'(i), r, e, lat);
      if (g == 0) begin
        op(1, 2, 32'h10, 32'hDEADBEEF, r, e, lat);
        chk("store latency", 32'(lat), 32'd2);
        chk("store err", {31'd0, e}, 32'd0);
        op(0, 2, 32'h10, 32'h0, r, e, lat);
        chk("load 0x10", r, 32'hDEADBEEF);
        op(1, 2, 32'h10, 32'h0, r, e, lat);
        op(1, 0, 32'h13, 32'hAAAAAAAA, r, e, lat);
        op(1, 1, 32'h10, 32'h55555555, r, e, lat);
        op(0, 2, 32'h10, 32'h0, r, e, lat);
        chk("lane merge", r, 32'hAA005555);
        op(1, 2, 32'h22, 32'hFFFFFFFF, r, e, lat);
        chk("misaligned store err", {31'd0, e}, 32'd1);
        op(0, 2, 32'h20, 32'h0, r, e, lat);
        chk("word 0x20 unchanged", r, 32'h1000_0008);
        op(0, 1, 32'h21, 32'h0, r, e, lat);
        chk("misaligned half err", {31'd0, e}, 32'd1);
        chk("misaligned half rdata", r, 32'd0);
        op(1, 2, 32'h1000, 32'hCAFEF00D, r, e, lat);
        op(0, 2, 32'h0, 32'h0, r, e, lat);
        chk("wrap load", r, 32'hCAFEF00D);
      end else if (g == 1) begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk) #1;
          req = i < 4; wr = 0; size = 2; addr = 32'(4 * i);
          @(negedge clk);
          if (i < 4) chk($sformatf("b2b addr_ok %0d", i), {31'd0, addr_ok}, 32'd1);
          if (i > 0) begin
            chk($sformatf("b2b data_ok %0d", i), {31'd0, data_ok}, 32'd1);
            chk($sformatf("b2b rdata %0d", i), rdata, 32'h1000_0000 + 32'(i - 1));
          end
        end
        @(posedge clk) #1;
        @(negedge clk);
        chk("b2b data_ok end", {31'd0, data_ok}, 32'd0);
      end else begin
        @(posedge clk) #1;
        req = 1; wr = 1; size = 2; addr = 32'h40; wdata = 32'h12345678;
        @(negedge clk);
        chk("rst test accept", {31'd0, addr_ok}, 32'd1);
        @(posedge clk) #1;
        req = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          chk($sformatf("mid-wait rst addr_ok %0d", i), {31'd0, addr_ok}, 32'd0);
          chk($sformatf("mid-wait rst data_ok %0d", i), {31'd0, data_ok}, 32'd0);
          @(posedge clk) #1;
        end
        rst = 0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk($sformatf("dropped data_ok %0d", i), {31'd0, data_ok}, 32'd0);
        end
        op(0, 2, 32'h40, 32'h0, r, e, lat);
        chk("dropped store not written", r, 32'h1000_0010);
      end
      for (int n = 0; n < 120; n++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3)),
           $urandom, r, e, lat);
        chk($sformatf("L%0d rand latency", L), 32'(lat), 32'(L));
      end
      repeat (3) @(posedge clk);
      done = 1;
    end
  end
  initial begin
    fork
      wait (u[0].done && u[1].done && u[2].done);
      #400000;
    join_any
    checks++;
    if (!(u[0].done && u[1].done && u[2].done)) begin
      errors++;
      $display("FAIL global_timeout: done=%b%b%b required 111", u[0].done, u[1].done, u[2].done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
